median_stream_filter: RTL

//  Parametrised streaming median filter: a sliding window of WINDOW samples over one input stream.

---
 rtl/median_stream_pkg.sv | 20 ++
 rtl/median_rank_select.sv | 44 ++++
 rtl/median_stream_filter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/median_stream_pkg.sv
// rtl/median_stream_pkg.sv - shared state type and window helpers for the median stream filter
package median_stream_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int mid_rank(input int window);
        return (window - 1) / 2;
    endfunction

    function automatic int rank_width(input int window);
        return $clog2(window);
    endfunction

endpackage

// File: rtl/median_rank_select.sv
// rtl/median_rank_select.sv - combinational rank computation and mid-rank selection over a window
// Ranks and selection have separate inputs so the top can register ranks between them (MEDIAN_PIPE_EN).
module median_rank_select
    import median_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WINDOW = 3,
    parameter int RANK_W = rank_width(WINDOW)
) (
    input  logic [WINDOW*DATA_W-1:0] i_rank_win,
    output logic [WINDOW*RANK_W-1:0] o_ranks,
    input  logic [WINDOW*DATA_W-1:0] i_sel_win,
    input  logic [WINDOW*RANK_W-1:0] i_sel_ranks,
    output logic [DATA_W-1:0]        o_median
);

    localparam logic [RANK_W-1:0] MID = RANK_W'(mid_rank(WINDOW));

    logic [RANK_W-1:0] w_rank;

    // Equal values are ordered by index, so ranks form a permutation and exactly one hits MID.
    always_comb begin
        o_ranks = '0;
        w_rank  = '0;
        for (int i = 0; i < WINDOW; i++) begin
            w_rank = '0;
            for (int j = 0; j < WINDOW; j++) begin
                if ((i_rank_win[j*DATA_W +: DATA_W] < i_rank_win[i*DATA_W +: DATA_W]) ||
                    ((j < i) && (i_rank_win[j*DATA_W +: DATA_W] == i_rank_win[i*DATA_W +: DATA_W])))
                    w_rank = w_rank + RANK_W'(1);
            end
            o_ranks[i*RANK_W +: RANK_W] = w_rank;
        end
    end

    always_comb begin
        o_median = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (i_sel_ranks[i*RANK_W +: RANK_W] == MID)
                o_median = i_sel_win[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/median_stream_filter.sv
// rtl/median_stream_filter.sv - framed sliding-window median filter with valid/ready on both sides
// Optional MEDIAN_PIPE_EN adds a rank register stage (latency 2 instead of 1).
module median_stream_filter
    import median_stream_pkg::*;
#(
    parameter int   DATA_W      = 32,
    parameter int   WINDOW      = 3,
    parameter int   NUM_SAMPLES = 8533,
    localparam int  CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data
);

    localparam int RANK_W = rank_width(WINDOW);

    if (NUM_SAMPLES < WINDOW) begin : g_bad_num_samples
        $error("NUM_SAMPLES must be >= WINDOW");
    end
    if ((WINDOW < 3) || (WINDOW > 9) || ((WINDOW % 2) == 0)) begin : g_bad_window
        $error("WINDOW must be odd and within 3..9");
    end

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [WINDOW*DATA_W-1:0] r_win;
    logic [WINDOW*DATA_W-1:0] w_next_win;
    logic [WINDOW*RANK_W-1:0] w_ranks;
    logic [WINDOW*DATA_W-1:0] w_sel_win;
    logic [WINDOW*RANK_W-1:0] w_sel_ranks;
    logic [DATA_W-1:0]        w_median;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_out_data;
    logic                     w_in_fire;
    logic                     w_run_fire;
    logic                     w_start_ok;
    logic                     w_out_free;
    logic                     w_stage_free;
    logic                     w_empty;

    // Newest sample enters at the top slice, oldest drops off the bottom.
    assign w_next_win = {i_in_data, r_win[WINDOW*DATA_W-1:DATA_W]};
    assign w_in_fire  = i_in_valid & o_in_ready;
    assign w_run_fire = w_in_fire & (r_state == RUN);
    assign w_start_ok = i_start & ((r_state == IDLE) | (r_state == DONE));
    assign w_out_free = ~r_out_valid | i_out_ready;

    median_rank_select #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW),
        .RANK_W (RANK_W)
    ) u_rank_select (
        .i_rank_win  (w_next_win),
        .o_ranks     (w_ranks),
        .i_sel_win   (w_sel_win),
        .i_sel_ranks (w_sel_ranks),
        .o_median    (w_median)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = FILL;
            FILL:    if (w_in_fire && (r_cnt == CNT_W'(WINDOW - 2))) w_state_next = RUN;
            RUN:     if (w_in_fire && (r_cnt == CNT_W'(NUM_SAMPLES - 1))) w_state_next = FLUSH;
            FLUSH:   if (w_empty) w_state_next = DONE;
            DONE:    if (i_start) w_state_next = FILL;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_in_ready = 1'b0;
        case (r_state)
            FILL, RUN: begin
                o_busy     = 1'b1;
                o_in_ready = w_stage_free;
            end
            FLUSH:   o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_win <= '0;
        end else if (w_start_ok) begin
            r_cnt <= '0;
            r_win <= '0;
        end else if (w_in_fire) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_win <= w_next_win;
        end
    end

`ifdef MEDIAN_PIPE_EN
    logic                     r_p_valid;
    logic [WINDOW*DATA_W-1:0] r_p_win;
    logic [WINDOW*RANK_W-1:0] r_p_ranks;

    assign w_sel_win    = r_p_win;
    assign w_sel_ranks  = r_p_ranks;
    assign w_stage_free = ~r_p_valid | w_out_free;
    assign w_empty      = ~r_p_valid & ~r_out_valid;

    // Rank stage refills in the same cycle it hands its contents to the output stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p_valid   <= 1'b0;
            r_p_win     <= '0;
            r_p_ranks   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_run_fire) begin
                r_p_valid <= 1'b1;
                r_p_win   <= w_next_win;
                r_p_ranks <= w_ranks;
            end else if (w_out_free) begin
                r_p_valid <= 1'b0;
            end
            if (w_out_free) begin
                r_out_valid <= r_p_valid;
                if (r_p_valid)
                    r_out_data <= w_median;
            end
        end
    end
`else
    assign w_sel_win    = w_next_win;
    assign w_sel_ranks  = w_ranks;
    assign w_stage_free = w_out_free;
    assign w_empty      = ~r_out_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_run_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_median;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule
